// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage and the multi-cycle MDU. The pipeline wins every collision; MDU
// results that lose are parked in a small FIFO and drained into idle write
// slots. A starvation counter raises a one-cycle pipeline stall so that the
// FIFO is guaranteed to make progress. Decode can query pending destinations
// through the pend_hit flags to stall on RAW hazards.
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   pipe_we/waddr/wdata         pipeline writeback request
//   mdu_valid/waddr/wdata       MDU result, accepted when mdu_ready=1
//   mdu_ready                   FIFO has a free slot (pop in same cycle does not count)
//   rf_we/waddr/wdata           register-file write port (combinational)
//   rd_addr_a/b                 decode read addresses
//   pend_hit_a/b                read address matches a valid buffered result
//   pipe_stall_req              registered one-cycle pipeline freeze
//   buf_count                   occupied FIFO slots (valid and squashed)
module wb_port_arbiter #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CW           = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pipe_we,
   input  logic [4:0]    pipe_waddr,
   input  logic [31:0]   pipe_wdata,
   input  logic          mdu_valid,
   output logic          mdu_ready,
   input  logic [4:0]    mdu_waddr,
   input  logic [31:0]   mdu_wdata,
   output logic          rf_we,
   output logic [4:0]    rf_waddr,
   output logic [31:0]   rf_wdata,
   input  logic [4:0]    rd_addr_a,
   input  logic [4:0]    rd_addr_b,
   output logic          pend_hit_a,
   output logic          pend_hit_b,
   output logic          pipe_stall_req,
   output logic [CW-1:0] buf_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   // Source driving the write port this cycle.
   typedef enum logic [1:0] {
      SRC_NONE,
      SRC_PIPE,
      SRC_HEAD,
      SRC_MDU
   } src_e;

   logic [4:0]       ent_addr [DEPTH];
   logic [31:0]      ent_data [DEPTH];
   // A valid bit is only ever set on an occupied slot and is cleared on pop,
   // so it doubles as "occupied and not squashed" for the pend_hit search.
   logic [DEPTH-1:0] ent_valid;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [CW-1:0]    count;
   logic [SW-1:0]    starve_cnt;
   logic             stall_q;

   src_e             src;
   logic             fifo_empty;
   logic             head_valid;
   logic             pipe_ok;
   logic             pipe_grant;
   logic             pop;
   logic             enq;
   logic             enq_valid;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      fifo_empty = (count == '0);
      head_valid = !fifo_empty && ent_valid[head];
      pipe_ok    = pipe_we && (pipe_waddr != '0);
      mdu_ready  = !rst && (count < CW'(DEPTH));

      src = SRC_NONE;
      if (rst) begin
         src = SRC_NONE;
      end else if (stall_q && head_valid) begin
         src = SRC_HEAD;
      end else if (pipe_ok) begin
         src = SRC_PIPE;
      end else if (head_valid) begin
         src = SRC_HEAD;
      end else if (mdu_valid && fifo_empty && (mdu_waddr != '0)) begin
         src = SRC_MDU;
      end

      pipe_grant = (src == SRC_PIPE);
      // A squashed head leaves without touching the port.
      pop        = !rst && !fifo_empty && ((src == SRC_HEAD) || !ent_valid[head]);
      enq        = mdu_ready && mdu_valid && (src != SRC_MDU) && (mdu_waddr != '0);
      // A same-cycle pipeline write to the same register supersedes the new entry.
      enq_valid  = !(pipe_grant && (pipe_waddr == mdu_waddr));
   end

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      unique case (src)
         SRC_PIPE: begin
            rf_we    = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
         end
         SRC_HEAD: begin
            rf_we    = 1'b1;
            rf_waddr = ent_addr[head];
            rf_wdata = ent_data[head];
         end
         SRC_MDU: begin
            rf_we    = 1'b1;
            rf_waddr = mdu_waddr;
            rf_wdata = mdu_wdata;
         end
         default: begin
            rf_we = 1'b0;
         end
      endcase
   end

   always_comb begin
      pend_hit_a = 1'b0;
      pend_hit_b = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (ent_valid[i] && (ent_addr[i] == rd_addr_a)) pend_hit_a = 1'b1;
         if (ent_valid[i] && (ent_addr[i] == rd_addr_b)) pend_hit_b = 1'b1;
      end
      if (rst || (rd_addr_a == '0)) pend_hit_a = 1'b0;
      if (rst || (rd_addr_b == '0)) pend_hit_b = 1'b0;
   end

   // Payload storage needs no reset; validity is tracked separately.
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_addr[tail] <= mdu_waddr;
         ent_data[tail] <= mdu_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ent_valid  <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         stall_q    <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pipe_grant && (ent_addr[i] == pipe_waddr)) ent_valid[i] <= 1'b0;
         end
         if (pop) begin
            ent_valid[head] <= 1'b0;
            head            <= ptr_inc(head);
         end
         if (enq) begin
            ent_valid[tail] <= enq_valid;
            tail            <= ptr_inc(tail);
         end
         count <= count + CW'(enq) - CW'(pop);

         if (fifo_empty || pop) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
         end else if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
            starve_cnt <= '0;
            stall_q    <= 1'b1;
         end else begin
            starve_cnt <= starve_cnt + SW'(1);
            stall_q    <= 1'b0;
         end
      end
   end

   assign pipe_stall_req = stall_q;
   assign buf_count      = count;

endmodule
